// File: rtl/alu.sv
// Registered 8-bit signed two-bank ALU; result c updates one clock after inputs are sampled.
// Latency: 1 cycle (posedge clk). No handshake: ALU_en=0 or a NULL opcode holds c.
// Backpressure: none; the block accepts a new operation every cycle.
module alu (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ALU_en,
  input  logic       a_en,
  input  logic       b_en,
  input  logic [2:0] a_op,
  input  logic [1:0] b_op,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] c
);

  logic [7:0] c_nxt;

  // Every path not explicitly computing a result falls back to holding c.
  always_comb begin
    c_nxt = c;
    if (ALU_en) begin
      case ({a_en, b_en})
        2'b10: begin
          case (a_op)
            3'd0:    c_nxt = A + B;
            3'd1:    c_nxt = A - B;
            3'd2:    c_nxt = A ^ B;
            3'd3:    c_nxt = A & B;
            3'd4:    c_nxt = A & B;
            3'd5:    c_nxt = A | B;
            3'd6:    c_nxt = ~(A ^ B);
            default: c_nxt = c;
          endcase
        end
        2'b01: begin
          case (b_op)
            2'd0:    c_nxt = ~(A & B);
            2'd1:    c_nxt = A + B;
            2'd2:    c_nxt = A + B;
            default: c_nxt = c;
          endcase
        end
        2'b11: begin
          case (b_op)
            2'd0:    c_nxt = A ^ B;
            2'd1:    c_nxt = ~(A ^ B);
            2'd2:    c_nxt = A - 8'd1;
            default: c_nxt = B + 8'd2;
          endcase
        end
        default: c_nxt = c;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) c <= 8'h00;
    else        c <= c_nxt;
  end

endmodule

// File: tb/tb_alu.sv
// Bench for alu: directed literal checks plus randomized traffic against a behavioural model,
// with every negedge comparing c to the model once checking is enabled.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ALU_en;
  logic       a_en;
  logic       b_en;
  logic [2:0] a_op;
  logic [1:0] b_op;
  logic [7:0] A;
  logic [7:0] B;
  logic [7:0] c;

  logic [7:0] exp_c;
  logic       chk_on = 1'b0;
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         cov_a [8];
  bit         cov_b1 [4];
  bit         cov_b2 [4];
  bit         cov_null, cov_dis;

  alu dut (
    .clk(clk), .rst_n(rst_n), .ALU_en(ALU_en), .a_en(a_en), .b_en(b_en),
    .a_op(a_op), .b_op(b_op), .A(A), .B(B), .c(c)
  );

  always #5 clk = ~clk;

  // Result table written directly from the operation list, in signed integer arithmetic.
  function automatic logic [7:0] model(input logic [7:0] cur, input logic en,
                                       input logic ae, input logic be,
                                       input logic [2:0] aop, input logic [1:0] bop,
                                       input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!en) return cur;
    if (ae && !be) begin
      if (aop == 0) return 8'(sa + sb);
      if (aop == 1) return 8'(sa - sb);
      if (aop == 2) return a ^ b;
      if (aop == 3 || aop == 4) return a & b;
      if (aop == 5) return a | b;
      if (aop == 6) return ~(a ^ b);
      return cur;
    end
    if (!ae && be) begin
      if (bop == 0) return ~(a & b);
      if (bop == 1 || bop == 2) return 8'(sa + sb);
      return cur;
    end
    if (ae && be) begin
      if (bop == 0) return a ^ b;
      if (bop == 1) return ~(a ^ b);
      if (bop == 2) return 8'(sa - 1);
      return 8'(sb + 2);
    end
    return cur;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_c <= 8'h00;
    else        exp_c <= model(exp_c, ALU_en, a_en, b_en, a_op, b_op, A, B);
  end

  task automatic chk(input string nm, input logic [7:0] expv);
    n_tests++;
    if (c !== expv) begin
      n_fail++;
      $display("FAIL %s: c=%h expected %h", nm, c, expv);
    end
  endtask

  // Drive at posedge+1, let one edge capture, return at the following posedge+1.
  task automatic op(input logic en, input logic ae, input logic be, input logic [2:0] aop,
                    input logic [1:0] bop, input logic [7:0] a, input logic [7:0] b);
    ALU_en = en; a_en = ae; b_en = be; a_op = aop; b_op = bop; A = a; B = b;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] ext [5];
    ext[0] = 8'h80; ext[1] = 8'hFF; ext[2] = 8'h00; ext[3] = 8'h01; ext[4] = 8'h7F;
    if ($urandom_range(3) == 0) return ext[$urandom_range(4)];
    return 8'($urandom);
  endfunction

  logic [2:0] a_ops [7];
  logic [7:0] a_exp [7];

  initial begin
    rst_n = 1'b0; ALU_en = 1'b0; a_en = 1'b0; b_en = 1'b0;
    a_op = 3'd0; b_op = 2'd0; A = 8'h00; B = 8'h00;
    fork
      begin : compare_loop
        forever begin
          @(negedge clk);
          if (chk_on) begin
            n_tests++;
            if (c !== exp_c) begin
              n_fail++;
              $display("FAIL model_cmp @%0t: c=%h expected %h", $time, c, exp_c);
            end
          end
        end
      end
      begin : main_seq
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        chk("reset_state", 8'h00);
        rst_n = 1'b1;

        // Asynchronous clear between edges, held while low, first update after release.
        op(1, 1, 0, 0, 0, 8'd80, 8'd5);
        chk("pre_reset_55", 8'h55);
        rst_n = 1'b0;
        #1;
        chk("async_clear", 8'h00);
        @(posedge clk); #1;
        chk("held_in_reset", 8'h00);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_after_reset", 8'h55);

        a_ops = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
        a_exp = '{8'h08, 8'h02, 8'h06, 8'h01, 8'h01, 8'h07, 8'hF9};
        for (int i = 0; i < 7; i++) begin
          op(1, 1, 0, a_ops[i], 2'($urandom), 8'd5, 8'd3);
          chk($sformatf("a_bank_op%0d", a_ops[i]), a_exp[i]);
        end

        op(1, 1, 0, 0, 0, 8'h7F, 8'h01);
        chk("wrap_add", 8'h80);
        op(1, 1, 0, 1, 0, 8'h80, 8'h01);
        chk("wrap_sub", 8'h7F);

        op(1, 0, 1, 3'd5, 0, 8'hF0, 8'h3C);
        chk("b1_nand", 8'hCF);
        op(1, 1, 1, 3'd2, 2, 8'h00, 8'h7F);
        chk("b2_dec", 8'hFF);
        op(1, 1, 1, 3'd2, 3, 8'h00, 8'h7F);
        chk("b2_add2_wrap", 8'h81);

        op(1, 1, 0, 0, 0, 8'd5, 8'd3);
        chk("hold_setup", 8'h08);
        op(0, 1, 0, 1, 0, 8'h11, 8'h22);
        chk("hold_disabled", 8'h08);
        op(1, 1, 0, 7, 0, 8'h11, 8'h22);
        chk("hold_a_null", 8'h08);
        op(1, 0, 1, 0, 3, 8'h11, 8'h22);
        chk("hold_b1_null", 8'h08);
        op(1, 0, 0, 0, 0, 8'h11, 8'h22);
        chk("hold_bank_00", 8'h08);

        for (int i = 0; i < 2000; i++) begin
          rst_n = ($urandom_range(99) != 0);
          ALU_en = ($urandom_range(4) != 0);
          a_en = 1'($urandom); b_en = 1'($urandom);
          a_op = 3'($urandom); b_op = 2'($urandom);
          A = pick_operand(); B = pick_operand();
          if (rst_n) begin
            if (!ALU_en) cov_dis = 1'b1;
            else if (a_en && !b_en) cov_a[a_op] = 1'b1;
            else if (!a_en && b_en) cov_b1[b_op] = 1'b1;
            else if (a_en && b_en) cov_b2[b_op] = 1'b1;
            else cov_null = 1'b1;
          end
          @(posedge clk); #1;
        end
        rst_n = 1'b1;
        @(negedge clk); #1;

        begin
          int hit;
          hit = int'(cov_null) + int'(cov_dis);
          foreach (cov_a[k]) hit += int'(cov_a[k]);
          foreach (cov_b1[k]) hit += int'(cov_b1[k]);
          foreach (cov_b2[k]) hit += int'(cov_b2[k]);
          n_tests++;
          if (hit != 18) begin
            n_fail++;
            $display("FAIL coverage: %0d bank/opcode bins hit, required 18", hit);
          end
        end
      end
    join_any
    disable fork;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
